issue_exec_div_unit: RTL



---
 rtl/div_unit_pkg.sv | 26 ++
 rtl/div_result_fifo.sv | 67 ++++++
 rtl/issue_exec_div_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared types for the divide issue/execute unit: FSM states, result-queue entry
// layout and flag bit positions. Entry fields are sized for the widest supported build.
package div_unit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } div_state_e;

  localparam int DIV_VAL_W_MAX = 128;
  localparam int DIV_CMD_W_MAX = 32;
  localparam int DIV_TAG_W_MAX = 16;
  localparam int DIV_FLAGS_W   = 4;

  localparam int DIV_FLAG_DZ = 0;

  // Narrower configurations leave the upper bits of each field at zero.
  typedef struct packed {
    logic [DIV_VAL_W_MAX-1:0] val;
    logic [DIV_CMD_W_MAX-1:0] cmd;
    logic [DIV_TAG_W_MAX-1:0] tag;
    logic [DIV_FLAGS_W-1:0]   flags;
  } div_entry_t;

endpackage

// File: rtl/div_result_fifo.sv
// Small circular result queue: push/pop in the same cycle keeps the count, flush empties it.
// The head reads as zero while the queue is empty.
module div_result_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DW-1:0]              wdata_i,
  output logic [DW-1:0]              rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i & (cnt_q != '0);
  assign do_push = push_i & ((cnt_q != CW'(DEPTH)) | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = ptr_inc(wr_q);
    if (do_pop)  rd_d = ptr_inc(rd_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
    end
  end

  assign rdata_o = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/issue_exec_div_unit.sv
// Radix-2 restoring divide issue/execute stage (signed/unsigned, quotient/remainder)
// with a result queue. Optional DIV_FAST_PATH_EN skips iteration for trivial operands.
module issue_exec_div_unit
  import div_unit_pkg::*;
#(
  parameter  int WIDTH          = 64,
  parameter  int ROBsize        = 16,
  parameter  int CMD_W          = 10,
  parameter  int OUT_DEPTH      = 2,
  parameter  int CMD_SIGNED_BIT = 0,
  parameter  int CMD_REM_BIT    = 1,
  localparam int TAG_W          = $clog2(ROBsize + 1)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] reservationStationVal1_i,
  input  logic [WIDTH-1:0] reservationStationVal2_i,
  input  logic [CMD_W-1:0] reservationStationCommands_i,
  input  logic [TAG_W-1:0] reservationStationTag_i,
  input  logic             readyRS_i,
  output logic             stallRS_o,
  input  logic             canGo_i,
  output logic [WIDTH-1:0] executeVal_o,
  output logic [CMD_W-1:0] executeCommands_o,
  output logic [TAG_W-1:0] executeTag_o,
  output logic [3:0]       executeFlags_o,
  output logic             valid_o
);

  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int QCNT_W = $clog2(OUT_DEPTH + 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, dz_q, dz_d;

  logic              op_signed, a_neg, b_neg, accept, push, pop;
  logic [WIDTH-1:0]  a_abs, b_abs, q_fix, r_fix;
  logic [WIDTH:0]    rem_shift, rem_diff;
  logic [QCNT_W-1:0] fifo_count;
  div_entry_t        push_entry, head;
  logic              unused_head_bits;

  assign op_signed = reservationStationCommands_i[CMD_SIGNED_BIT];
  assign a_neg     = op_signed & reservationStationVal1_i[WIDTH-1];
  assign b_neg     = op_signed & reservationStationVal2_i[WIDTH-1];
  assign a_abs     = a_neg ? -reservationStationVal1_i : reservationStationVal1_i;
  assign b_abs     = b_neg ? -reservationStationVal2_i : reservationStationVal2_i;

  assign accept    = readyRS_i & (state_q == IDLE) & (fifo_count < QCNT_W'(OUT_DEPTH)) & ~flush_i;
  assign stallRS_o = ~accept;
  assign valid_o   = (fifo_count != '0);
  assign pop       = canGo_i & valid_o;

  // quo_q doubles as the dividend shift register: dividend bits leave the top as quotient bits enter.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, dvs_q};

`ifdef DIV_FAST_PATH_EN
  logic min_neg1, fast_path;
  assign min_neg1  = op_signed & (reservationStationVal1_i == {1'b1, {(WIDTH-1){1'b0}}})
                   & (&reservationStationVal2_i);
  assign fast_path = (reservationStationVal2_i == '0) | min_neg1 | (a_abs < b_abs);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cmd_d   = cmd_q;
    tag_d   = tag_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = CNT_W'(WIDTH);
          rem_d   = '0;
          quo_d   = a_abs;
          dvs_d   = b_abs;
          cmd_d   = reservationStationCommands_i;
          tag_d   = reservationStationTag_i;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          dz_d    = (reservationStationVal2_i == '0);
          state_d = CALC;
`ifdef DIV_FAST_PATH_EN
          if (fast_path) begin
            quo_d   = (reservationStationVal2_i == '0) ? '1 : (min_neg1 ? a_abs : '0);
            rem_d   = min_neg1 ? '0 : a_abs;
            state_d = FIX;
          end
`endif
        end
      end
      CALC: begin
        rem_d = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~rem_diff[WIDTH]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      push    = 1'b0;
    end
  end

  always_comb begin
    q_fix = dz_q ? '1 : (q_neg_q ? -quo_q : quo_q);
    r_fix = r_neg_q ? -rem_q : rem_q;
    push_entry                    = '0;
    push_entry.val                = DIV_VAL_W_MAX'(cmd_q[CMD_REM_BIT] ? r_fix : q_fix);
    push_entry.cmd                = DIV_CMD_W_MAX'(cmd_q);
    push_entry.tag                = DIV_TAG_W_MAX'(tag_q);
    push_entry.flags[DIV_FLAG_DZ] = dz_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cmd_q   <= '0;
      tag_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cmd_q   <= cmd_d;
      tag_q   <= tag_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
    end
  end

  div_result_fifo #(
    .DEPTH(OUT_DEPTH),
    .DW   ($bits(div_entry_t))
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .flush_i  (flush_i),
    .push_i   (push),
    .pop_i    (pop),
    .wdata_i  (push_entry),
    .rdata_o  (head),
    .count_o  (fifo_count)
  );

  assign executeVal_o      = head.val[WIDTH-1:0];
  assign executeCommands_o = head.cmd[CMD_W-1:0];
  assign executeTag_o      = head.tag[TAG_W-1:0];
  assign executeFlags_o    = head.flags;
  assign unused_head_bits  = ^head;

endmodule
